ddr_rd_buffer: RTL and testbench

DDR_RD_BUFFER -- requirements
Module: ddr_rd_buffer

---
 rtl/ddr_rd_buf_pkg.sv | 15 +
 rtl/ddr_rd_buf_ram.sv | 50 +++++
 rtl/ddr_rd_buffer.sv | 159 +++++++++++++++
 tb/tb_ddr_rd_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_buf_pkg.sv
// ddr_rd_buf_pkg
// Shared defaults and request-FSM state encoding for the DDR read buffer.
// Optional build macro: RD_BUF_STAT_EN (adds overflow/underflow statistics).
package ddr_rd_buf_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 64;
    localparam int BURST_LEN_DEF  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_e;

endpackage

// File: rtl/ddr_rd_buf_ram.sv
// ddr_rd_buf_ram
// Simple dual-port RAM with one write port and one registered read port,
// single clock. The read register only loads when re_i is high, so the
// output holds the last word read.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (clears the read register only)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable
//   raddr_i  read address
//   rdata_o  registered read data
module ddr_rd_buf_ram
    import ddr_rd_buf_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdataQ;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdataQ <= '0;
        end else if (re_i) begin
            rdataQ <= mem[raddr_i];
        end
    end

    assign rdata_o = rdataQ;

endmodule

// File: rtl/ddr_rd_buffer.sv
// ddr_rd_buffer
// Buffers DDR read-return words for the wavelet engine and throttles new DDR
// read requests so that buffered words plus words still in flight never
// exceed the buffer depth.
// Optional build macro: RD_BUF_STAT_EN adds ovf_sticky, udf_sticky, drop_cnt.
// Ports:
//   clk         phy clock
//   reset       asynchronous active-low reset
//   write_fifo  DDR read-data valid strobe
//   wr_data     DDR read data
//   rd_addr_up  pulse: controller accepted a BURST_LEN-word read
//   r_req       read request to the DDR controller (level)
//   rd_en       pop request
//   rd_data     popped word (holds last value)
//   rd_valid    rd_data valid, one cycle
//   level       current word count
module ddr_rd_buffer
    import ddr_rd_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_fifo,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_addr_up,
    output logic                    r_req,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
`ifdef RD_BUF_STAT_EN
    output logic                    ovf_sticky,
    output logic                    udf_sticky,
    output logic [15:0]             drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = LW + 1;
    localparam int SW = OW + 1;
    localparam int OUT_MAX = (1 << OW) - 1;

    logic [LW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [LW-1:0] levelW;
    logic [OW-1:0] outQ, outD;
    logic [SW-1:0] outSum, creditSum;
    logic          rdValidQ;
    logic          full, empty, wrAcc, popAcc, creditOk;
    req_state_e    stateQ, stateD;

    // Pointers carry one extra MSB, so their difference is the fill level
    // and distinguishes full from empty.
    assign levelW = wrPtrQ - rdPtrQ;
    assign full   = (levelW == LW'(DEPTH));
    assign empty  = (levelW == '0);
    assign wrAcc  = write_fifo & ~full;
    assign popAcc = rd_en & ~empty;

    assign wrPtrD = wrAcc  ? wrPtrQ + LW'(1) : wrPtrQ;
    assign rdPtrD = popAcc ? rdPtrQ + LW'(1) : rdPtrQ;

    // Outstanding words: grow by a burst on each accepted read, shrink by one
    // per returned word, never below zero.
    always_comb begin
        outSum = SW'(outQ);
        if (rd_addr_up) begin
            outSum = outSum + SW'(BURST_LEN);
        end
        if (write_fifo && (outSum != '0)) begin
            outSum = outSum - SW'(1);
        end
        if (outSum > SW'(OUT_MAX)) begin
            outD = OW'(OUT_MAX);
        end else begin
            outD = OW'(outSum);
        end
    end

    // Another burst is only requested if it is guaranteed to fit.
    assign creditSum = SW'(levelW) + SW'(outQ) + SW'(BURST_LEN);
    assign creditOk  = (creditSum <= SW'(DEPTH));

    // Leaving REQ on rd_addr_up forces a fresh credit check before the next
    // request, because the accepted burst is not yet counted in outQ.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_IDLE: if (creditOk) stateD = ST_REQ;
            ST_REQ:  if (rd_addr_up || !creditOk) stateD = ST_IDLE;
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            outQ     <= '0;
            stateQ   <= ST_IDLE;
            rdValidQ <= 1'b0;
        end else begin
            wrPtrQ   <= wrPtrD;
            rdPtrQ   <= rdPtrD;
            outQ     <= outD;
            stateQ   <= stateD;
            rdValidQ <= popAcc;
        end
    end

    ddr_rd_buf_ram #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (wrAcc),
        .waddr_i (wrPtrQ[AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (popAcc),
        .raddr_i (rdPtrQ[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign r_req    = (stateQ == ST_REQ);
    assign rd_valid = rdValidQ;
    assign level    = levelW;

`ifdef RD_BUF_STAT_EN
    logic        ovfQ, udfQ;
    logic [15:0] dropQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovfQ  <= 1'b0;
            udfQ  <= 1'b0;
            dropQ <= '0;
        end else begin
            if (write_fifo && full) begin
                ovfQ <= 1'b1;
                if (dropQ != 16'hFFFF) begin
                    dropQ <= dropQ + 16'd1;
                end
            end
            if (rd_en && empty) begin
                udfQ <= 1'b1;
            end
        end
    end

    assign ovf_sticky = ovfQ;
    assign udf_sticky = udfQ;
    assign drop_cnt   = dropQ;
`endif

endmodule

// File: tb/tb_ddr_rd_buffer.sv
// tb_ddr_rd_buffer
// Self-checking bench for ddr_rd_buffer: a table of directed vectors after
// reset, hand-written multi-cycle sequences for credit, overflow, underflow
// and mid-burst reset, then randomized traffic against a queue-based model.
// Optional build macro: RD_BUF_STAT_EN (also checks the statistics ports).
module tb_ddr_rd_buffer;
    import ddr_rd_buf_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int BL    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_fifo = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_addr_up = 1'b0;
    logic          rd_en = 1'b0;
    logic          r_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
`ifdef RD_BUF_STAT_EN
    logic          ovf_sticky;
    logic          udf_sticky;
    logic [15:0]   drop_cnt;
`endif

    always #5 clk = ~clk;

    ddr_rd_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_fifo (write_fifo),
        .wr_data    (wr_data),
        .rd_addr_up (rd_addr_up),
        .r_req      (r_req),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
`ifdef RD_BUF_STAT_EN
        .ovf_sticky (ovf_sticky),
        .udf_sticky (udf_sticky),
        .drop_cnt   (drop_cnt),
`endif
        .level      (level)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a word queue plus an outstanding-word count.
    logic [DW-1:0] mq[$];
    int            mOut;
    bit            mReq;
    bit            mValid;
    logic [DW-1:0] mData;
    bit            mOvf;
    bit            mUdf;
    int            mDrops;

    typedef struct {
        bit            wf;
        logic [DW-1:0] wd;
        bit            up;
        bit            re;
        int            expLevel;
        bit            expValid;
        logic [DW-1:0] expData;
        bit            expReq;
    } vec_t;

    vec_t vecs[14];

    task automatic modelReset();
        mq.delete();
        mOut   = 0;
        mReq   = 1'b0;
        mValid = 1'b0;
        mData  = '0;
        mOvf   = 1'b0;
        mUdf   = 1'b0;
        mDrops = 0;
    endtask

    // One clock of the model, evaluated from the state before the edge.
    task automatic modelStep(input bit wf, input logic [DW-1:0] wd, input bit up, input bit re);
        int lvl;
        bit credit;
        lvl    = mq.size();
        credit = (lvl + mOut + BL) <= DEPTH;
        mValid = re && (lvl > 0);
        if (mValid) mData = mq.pop_front();
        if (wf && lvl < DEPTH) mq.push_back(wd);
        if (wf && lvl == DEPTH) begin
            mOvf = 1'b1;
            if (mDrops < 65535) mDrops++;
        end
        if (re && lvl == 0) mUdf = 1'b1;
        mOut = mOut + (up ? BL : 0) - (wf ? 1 : 0);
        if (mOut < 0) mOut = 0;
        mReq = mReq ? (credit && !up) : credit;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".level"},    64'(level),    64'(mq.size()));
        checkOutput({tag, ".r_req"},    64'(r_req),    64'(mReq));
        checkOutput({tag, ".rd_valid"}, 64'(rd_valid), 64'(mValid));
        checkOutput({tag, ".rd_data"},  64'(rd_data),  64'(mData));
`ifdef RD_BUF_STAT_EN
        checkOutput({tag, ".ovf"},  64'(ovf_sticky), 64'(mOvf));
        checkOutput({tag, ".udf"},  64'(udf_sticky), 64'(mUdf));
        checkOutput({tag, ".drop"}, 64'(drop_cnt),   64'(mDrops));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic applyStimulus(input bit wf, input logic [DW-1:0] wd, input bit up, input bit re);
        write_fifo = wf;
        wr_data    = wd;
        rd_addr_up = up;
        rd_en      = re;
        modelStep(wf, wd, up, re);
        @(posedge clk);
        #1;
        write_fifo = 1'b0;
        rd_addr_up = 1'b0;
        rd_en      = 1'b0;
    endtask

    task automatic doReset();
        write_fifo = 1'b0;
        rd_addr_up = 1'b0;
        rd_en      = 1'b0;
        reset      = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Directed vectors right after reset: idle, one burst of 0x11..0x14,
        // four pops, then empty-pop and write-with-pop at level 0.
        vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b1};
        vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0};
        vecs[2]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b0, 32'h00, 1'b1};
        vecs[3]  = '{1'b1, 32'h12, 1'b0, 1'b0, 2, 1'b0, 32'h00, 1'b1};
        vecs[4]  = '{1'b1, 32'h13, 1'b0, 1'b0, 3, 1'b0, 32'h00, 1'b1};
        vecs[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 4, 1'b0, 32'h00, 1'b1};
        vecs[6]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3, 1'b1, 32'h11, 1'b1};
        vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 2, 1'b1, 32'h12, 1'b1};
        vecs[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1, 1'b1, 32'h13, 1'b1};
        vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b1, 32'h14, 1'b1};
        vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0, 32'h14, 1'b1};
        vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b0, 32'h14, 1'b1};
        vecs[12] = '{1'b1, 32'h55, 1'b0, 1'b1, 1, 1'b0, 32'h14, 1'b1};
        vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b1, 32'h55, 1'b1};

        $display("[TB] reset and directed table");
        doReset();
        checkOutput("rst.level",    64'(level),    64'd0);
        checkOutput("rst.r_req",    64'(r_req),    64'd0);
        checkOutput("rst.rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst.rd_data",  64'(rd_data),  64'd0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wf, vecs[i].wd, vecs[i].up, vecs[i].re);
            checkOutput($sformatf("vec%0d.level", i),    64'(level),    64'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d.rd_valid", i), 64'(rd_valid), 64'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d.rd_data", i),  64'(rd_data),  64'(vecs[i].expData));
            checkOutput($sformatf("vec%0d.r_req", i),    64'(r_req),    64'(vecs[i].expReq));
        end
`ifdef RD_BUF_STAT_EN
        checkOutput("vec.udf", 64'(udf_sticky), 64'd1);
`endif

        // Credit limit: 16 accepted bursts exhaust the 64-word budget.
        $display("[TB] credit limit");
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkModel("cr.idle");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkModel($sformatf("cr.up%0d", i));
        end
        repeat (2) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkModel("cr.settle");
        end
        checkOutput("cr.r_req_off", 64'(r_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
            checkModel("cr.wr");
        end
        checkOutput("cr.r_req_still_off", 64'(r_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkModel("cr.pop");
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkModel("cr.after");
        checkOutput("cr.r_req_on", 64'(r_req), 64'd1);

        // Overflow: 64 words fill the buffer, the 65th is dropped.
        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        checkModel("ovf.fill");
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        checkModel("ovf.drop");
        checkOutput("ovf.level", 64'(level), 64'd64);
`ifdef RD_BUF_STAT_EN
        checkOutput("ovf.sticky", 64'(ovf_sticky), 64'd1);
        checkOutput("ovf.cnt",    64'(drop_cnt),   64'd1);
`endif
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkModel("ovf.drain");
        end
        checkOutput("ovf.last", 64'(rd_data), 64'h13F);

        // Underflow and simultaneous write+pop at level 5.
        $display("[TB] underflow and write+pop");
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkModel("udf.pop");
        checkOutput("udf.rd_valid", 64'(rd_valid), 64'd0);
`ifdef RD_BUF_STAT_EN
        checkOutput("udf.sticky", 64'(udf_sticky), 64'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h2AA, 1'b0, 1'b1);
        checkModel("wp.both");
        checkOutput("wp.level", 64'(level), 64'd5);
        checkOutput("wp.data",  64'(rd_data), 64'h200);

        // Reset in the middle of a burst.
        $display("[TB] mid-burst reset");
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        checkModel("mb.pre");
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("mb.level", 64'(level), 64'd0);
        checkOutput("mb.r_req", 64'(r_req), 64'd0);
        checkOutput("mb.valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("mb.r_req_rel", 64'(r_req), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkModel("mb.post");
        checkOutput("mb.r_req_up", 64'(r_req), 64'd1);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
        checkModel("mb.wr");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkModel("mb.pop1");
        checkOutput("mb.data1", 64'(rd_data), 64'hB1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkModel("mb.pop2");

        // Randomized traffic in three phases: fill-heavy, drain-heavy, mixed.
        $display("[TB] random traffic");
        doReset();
        for (int ph = 0; ph < 3; ph++) begin
            int pw;
            int pr;
            pw = (ph == 0) ? 80 : (ph == 1) ? 15 : 50;
            pr = (ph == 0) ? 10 : (ph == 1) ? 85 : 50;
            for (int c = 0; c < 300; c++) begin
                bit wf;
                bit up;
                bit re;
                wf = ($urandom % 100) < pw;
                re = ($urandom % 100) < pr;
                up = mReq && (($urandom % 4) == 0);
                applyStimulus(wf, $urandom, up, re);
                checkModel($sformatf("rnd%0d.%0d", ph, c));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
